// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver feeding a first-word-fall-through byte FIFO
// Optional even-parity frame support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ  = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx,
    input  logic                         rd_en,
    input  logic                         clear_errors,
    output logic [7:0]                   data_out,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(BUFFER_SIZE):0] count,
    output logic                         frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                         parity_error,
`endif
    output logic                         overflow
);

    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT   = BIT_CYCLES / 2;
    localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
    localparam int PTR_W      = $clog2(BUFFER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_n;
    logic             rx_s1, rx_s2, rx_d;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             push;
    logic             stop_sample;
    logic             par_bad, par_bad_n;

    logic [7:0]       mem [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             pop, push_ok, drop;

    // rx_d holds the previous synchronized level for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            par_bad <= par_bad_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        par_bad_n   = par_bad;
        push        = 1'b0;
        stop_sample = 1'b0;
        frame_error = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (rx_d && !rx_s2) begin
                    state_n   = S_START;
                    bit_idx_n = '0;
                    par_bad_n = 1'b0;
                end
            end
            S_START: begin
                if (cnt == CNT_W'(HALF_BIT - 1)) begin
                    cnt_n   = '0;
                    state_n = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s2, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (cnt == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    par_bad_n = (rx_s2 != ^shift);
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_W'(BIT_CYCLES - 1)) begin
                    cnt_n       = '0;
                    state_n     = S_IDLE;
                    stop_sample = 1'b1;
                    if (rx_s2) begin
                        push = !par_bad;
                    end else begin
                        frame_error = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A pop on a full FIFO frees the slot the incoming byte is written to
    assign pop      = rd_en && !empty;
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(BUFFER_SIZE));
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_errors) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_error <= 1'b0;
        end else if (stop_sample && par_bad) begin
            parity_error <= 1'b1;
        end else if (clear_errors) begin
            parity_error <= 1'b0;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = par_bad ^ stop_sample;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive path for the Grande Risco 5 SoC.
- Recovers 8-bit asynchronous frames from the `rx` pin and buffers them in a first-word-fall-through FIFO.
- The CPU peripheral bus drains the FIFO through a pop handshake.
- It is the receiving end of the SoC serial link, the counterpart of the UART transmitter, and sits between the board `rx` pin and the UART register block.

## Interface
- `CLOCK_FREQ`, 100000000 — system clock frequency in Hz.
- `BAUD_RATE`, 115200 — line rate in baud.
- `BUFFER_SIZE`, 16 — FIFO depth in bytes; must be a power of two, ≥ 2.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input; asynchronous to `clk`; idles high.
- `rd_en`  in  1  pop request; pops the head entry when `empty` = 0.
- `clear_errors`  in  1  clears the sticky `overflow` flag (and `parity_error` when configured).
- `data_out`  out  8  FIFO head byte; valid while `empty` = 0.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `BUFFER_SIZE` bytes.
- `count`  out  $clog2(BUFFER_SIZE)+1  number of bytes held.
- `frame_error`  out  1  one-cycle pulse on a bad stop bit.
- `overflow`  out  1  sticky; a received byte was dropped because the FIFO was full.

## Operation
- `BIT_CYCLES` = `CLOCK_FREQ` / `BAUD_RATE`, using integer division (868 at the defaults). `HALF_BIT` = `BIT_CYCLES` / 2.
- The synchronizer is two flops on `rx`; both reset to 1. All decisions use the synchronized value.
- The FSM has states IDLE, START, DATA, [PARITY], STOP.
  - IDLE: a synchronized high→low transition goes to START and clears the bit counter.
  - START: after `HALF_BIT` cycles, samples the line. Low goes to DATA. High is treated as a glitch and returns to IDLE with no flag raised.
  - DATA: samples every `BIT_CYCLES`. Data is LSB first and shifts into an 8-bit register. After the 8th sample, goes to PARITY (if configured), otherwise to STOP.
  - STOP: samples after `BIT_CYCLES`.
    - Sample = 1: push the byte.
    - Sample = 0: pulse `frame_error`, discard the byte.
    - Either way, return to IDLE in the same cycle. Re-arming at mid-stop-bit allows back-to-back frames.
- Push rules:
  - Push when not full: write at the tail and increment `count`.
  - Push when full without a pop: drop the byte and set `overflow`. Stored data is unchanged.
  - Push and pop in the same cycle, full or not: both happen; `count` is unchanged.
- Pop rules:
  - `rd_en` with `empty` = 1 is ignored.
  - A pop advances the head; the next entry appears on `data_out` the following cycle.
- Pointers are $clog2(BUFFER_SIZE) bits wide and wrap modulo `BUFFER_SIZE`.
- `clear_errors` clears the sticky flags. If a new overflow occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM in IDLE, pointers 0.
  - `data_out` 8'h00, `empty` 1, `full` 0, `count` 0.
  - `frame_error` 0, `overflow` 0, `parity_error` 0.
- Reset mid-frame aborts the frame; the partial byte is never pushed.
- Latency from the `rx` falling edge to entering START is 2–3 cycles (synchronizer).
- The push happens on the edge where the stop bit is sampled. `empty`, `count`, `full` and `data_out` reflect it on the next cycle.
- Pop is combinational-free: `rd_en` sampled at edge N means `count`, `empty` and `data_out` are updated after edge N.
- `frame_error` is high for exactly one cycle, coincident with the STOP sample.
- `overflow` and `parity_error` are registered; they assert one cycle after the offending stop sample.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - The frame carries an even-parity bit after the data bits.
  - A PARITY state samples it `BIT_CYCLES` after the last data bit.
  - A sticky `parity_error` output (1 bit) is added. It is set on mismatch, and the byte is not pushed. A set wins over `clear_errors` in the same cycle.
- Undefined: the frame is 8N1, the PARITY state and the `parity_error` port do not exist, and data goes directly to STOP.

## Test plan
- Single frame 0xA5 at 868 cycles/bit → after the stop sample: `empty` = 0, `data_out` = 8'hA5, `count` = 1. After one `rd_en`: `empty` = 1, `count` = 0.
- 17 back-to-back frames 0x00–0x10 with no pops → `full` = 1, `count` = 16, `overflow` = 1, `data_out` = 0x00. Popping all 16 yields 0x00–0x0F in order; `clear_errors` then drops `overflow` to 0.
- `rx` low for 200 cycles, then high → no push, no `frame_error`, FSM back in IDLE.
- Frame 0x3C with the stop bit held low → one-cycle `frame_error` pulse, `empty` stays 1. The next valid frame 0x55 is received correctly.
- Reset asserted during data bit 4 of 0xFF, then a frame 0x12 → only 0x12 is stored; `count` = 1.
- `UART_RX_PARITY_EN` defined, frame 0x07 with parity bit 0 (wrong; 0x07 needs 1) → `parity_error` = 1, `empty` = 1. Frame 0x07 with parity bit 1 → `data_out` = 8'h07.
